// File: rtl/lm75a_drive.sv
// LM75A temperature reader: periodic I2C read of the 11-bit temperature register.
// Contains the SCL quarter-bit divider, a byte-level sequencer and an open-drain SDA bit engine.
module lm75a_drive #(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ = 100_000,
  parameter logic [6:0] DEV_ADDR = 7'b1001000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        LM75A_EN,
  output logic [10:0] Temp_data,
  output logic        Read_temp_en,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  localparam int Q  = CLK_FREQ / SCL_FREQ / 4;
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);

  localparam logic [5:0] OP_WR   = 6'b000001;
  localparam logic [5:0] OP_STA  = 6'b000010;
  localparam logic [5:0] OP_RD   = 6'b000100;
  localparam logic [5:0] OP_STO  = 6'b001000;
  localparam logic [5:0] OP_ACK  = 6'b010000;
  localparam logic [5:0] OP_NACK = 6'b100000;

  typedef enum logic [3:0] {
    IDLE, START, WR_ADDR, WR_PTR, RSTART, RD_ADDR, RD_MSB, RD_LSB, STOP, DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [QW-1:0] qcnt_reg;
  logic [1:0]  quarter_reg;
  logic [3:0]  bit_reg;
  logic        scl_reg, scl_next;
  logic        sda_low_reg, sda_low_next;
  logic [1:0]  sda_sync_reg;
  logic [7:0]  rx_reg, msb_reg;
  logic [10:0] temp_reg;
  logic        strobe_reg;

  logic [5:0]  op;
  logic [7:0]  tx_byte;
  logic        busy, quarter_end, slot_end, op_done, sample, data_scl;

  // Operation for the current slot; the ninth slot of a write byte releases SDA like a NACK.
  always_comb begin
    op      = 6'b000000;
    tx_byte = 8'h00;
    case (state_reg)
      START, RSTART: op = OP_STA;
      WR_ADDR: begin
        tx_byte = {DEV_ADDR, 1'b0};
        op      = (bit_reg == 4'd8) ? OP_NACK : OP_WR;
      end
      WR_PTR: begin
        tx_byte = 8'h00;
        op      = (bit_reg == 4'd8) ? OP_NACK : OP_WR;
      end
      RD_ADDR: begin
        tx_byte = {DEV_ADDR, 1'b1};
        op      = (bit_reg == 4'd8) ? OP_NACK : OP_WR;
      end
      RD_MSB:  op = (bit_reg == 4'd8) ? OP_ACK : OP_RD;
      RD_LSB:  op = (bit_reg == 4'd8) ? OP_NACK : OP_RD;
      STOP:    op = OP_STO;
      default: op = 6'b000000;
    endcase
  end

  assign busy        = (op != 6'b000000);
  assign quarter_end = busy && (qcnt_reg == Q_LAST);
  assign slot_end    = quarter_end && (quarter_reg == 2'd3);
  assign op_done     = slot_end && (((op & (OP_STA | OP_STO)) != 6'b000000) || (bit_reg == 4'd8));
  assign sample      = quarter_end && (quarter_reg == 2'd1) && (op == OP_RD);
  assign data_scl    = quarter_reg[0] ^ quarter_reg[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (LM75A_EN) state_next = START;
      START:   if (op_done) state_next = WR_ADDR;
      WR_ADDR: if (op_done) state_next = WR_PTR;
      WR_PTR:  if (op_done) state_next = RSTART;
      RSTART:  if (op_done) state_next = RD_ADDR;
      RD_ADDR: if (op_done) state_next = RD_MSB;
      RD_MSB:  if (op_done) state_next = RD_LSB;
      RD_LSB:  if (op_done) state_next = STOP;
      STOP:    if (op_done) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Bus levels per quarter; idle leaves SCL high and SDA released.
  always_comb begin
    scl_next     = 1'b1;
    sda_low_next = 1'b0;
    case (op)
      OP_STA: begin
        scl_next     = (quarter_reg != 2'd3);
        sda_low_next = quarter_reg[1];
      end
      OP_STO: begin
        scl_next     = (quarter_reg != 2'd0);
        sda_low_next = ~quarter_reg[1];
      end
      OP_WR: begin
        scl_next     = data_scl;
        sda_low_next = ~tx_byte[3'd7 - bit_reg[2:0]];
      end
      OP_ACK: begin
        scl_next     = data_scl;
        sda_low_next = 1'b1;
      end
      OP_RD, OP_NACK: scl_next = data_scl;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      state_reg    <= IDLE;
      qcnt_reg     <= '0;
      quarter_reg  <= 2'd0;
      bit_reg      <= 4'd0;
      scl_reg      <= 1'b1;
      sda_low_reg  <= 1'b0;
      sda_sync_reg <= 2'b11;
      rx_reg       <= 8'h00;
      msb_reg      <= 8'h00;
      temp_reg     <= 11'h000;
      strobe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      scl_reg      <= scl_next;
      sda_low_reg  <= sda_low_next;
      sda_sync_reg <= {sda_sync_reg[0], i2c_sdat};
      strobe_reg   <= 1'b0;
      if (!busy) begin
        qcnt_reg    <= '0;
        quarter_reg <= 2'd0;
        bit_reg     <= 4'd0;
      end else begin
        qcnt_reg <= quarter_end ? '0 : qcnt_reg + 1'b1;
        if (quarter_end) quarter_reg <= quarter_reg + 2'd1;
        if (op_done) bit_reg <= 4'd0;
        else if (slot_end) bit_reg <= bit_reg + 4'd1;
      end
      if (sample) rx_reg <= {rx_reg[6:0], sda_sync_reg[1]};
      if (state_reg == RD_MSB && op_done) msb_reg <= rx_reg;
      // rx_reg still holds the LSB while STOP runs.
      if (state_reg == STOP && op_done) begin
        temp_reg   <= {msb_reg, rx_reg[7:5]};
        strobe_reg <= 1'b1;
      end
    end
  end

  assign Temp_data    = temp_reg;
  assign Read_temp_en = strobe_reg;
  assign i2c_sclk     = scl_reg;
  assign i2c_sdat     = sda_low_reg ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_lm75a_drive.sv
// Bench for lm75a_drive: bus monitor plus LM75A slave model, randomized readings
// checked against an arithmetic temperature model and the expected bus event list.
module tb_lm75a_drive;

  localparam int CLK_FREQ = 1_600_000;
  localparam int SCL_FREQ = 100_000;
  localparam int Q        = CLK_FREQ / SCL_FREQ / 4;
  localparam int TXN      = 48 * 4 * Q;
  localparam int EV_S     = 1000;
  localparam int EV_P     = 1001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [10:0] temp;
  logic        strobe;
  logic        scl;
  wire         sda;

  logic        slave_low = 1'b0;
  logic        slave_present = 1'b0;
  logic        mon_rst = 1'b1;
  logic [7:0]  msb_v = 8'h00;
  logic [7:0]  lsb_v = 8'h00;

  int compared = 0;
  int mismatched = 0;
  int ev_q[$];

  pullup (sda);
  assign sda = (slave_low && slave_present && !mon_rst) ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  lm75a_drive #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ)) dut (
    .Clk(clk),
    .Rst_n(rst),
    .LM75A_EN(en),
    .Temp_data(temp),
    .Read_temp_en(strobe),
    .i2c_sclk(scl),
    .i2c_sdat(sda)
  );

  // Bus monitor and LM75A slave: decodes START/STOP/bytes, drives ACKs and read data.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       cur_scl, cur_sda;
  logic [8:0] mon_sh = 9'h0;
  logic [7:0] rd_byte;
  int         bit_i = 0;
  int         byte_i = 0;

  always @(negedge clk) begin
    cur_scl = scl;
    cur_sda = (sda !== 1'b0);
    if (mon_rst) begin
      bit_i     = 0;
      byte_i    = 0;
      slave_low = 1'b0;
    end else if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
      ev_q.push_back(EV_S);
      bit_i = 0;
    end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
      ev_q.push_back(EV_P);
      bit_i     = 0;
      byte_i    = 0;
      slave_low = 1'b0;
    end else if (!prev_scl && cur_scl) begin
      mon_sh = {mon_sh[7:0], cur_sda};
      bit_i++;
      if (bit_i == 9) ev_q.push_back(int'(mon_sh));
    end else if (prev_scl && !cur_scl) begin
      rd_byte = (byte_i == 3) ? msb_v : lsb_v;
      if (bit_i == 8 && byte_i < 3) begin
        slave_low = 1'b1;
      end else if (bit_i == 9) begin
        byte_i++;
        bit_i = 0;
        if (byte_i == 3)      slave_low = ~msb_v[7];
        else if (byte_i == 4) slave_low = ~lsb_v[7];
        else                  slave_low = 1'b0;
      end else if (bit_i == 8) begin
        slave_low = 1'b0;
      end else if (byte_i >= 3 && byte_i <= 4 && bit_i >= 1) begin
        slave_low = ~rd_byte[3'(7 - bit_i)];
      end
    end
    prev_scl = cur_scl;
    prev_sda = cur_sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reading in 0.125 C steps: the 16-bit register value shifted down by five.
  function automatic logic [10:0] model_temp(input logic [7:0] m, input logic [7:0] l);
    int raw;
    raw = (int'(m) << 8) | int'(l);
    return 11'((raw >> 5) & 32'h7FF);
  endfunction

  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!strobe && cycles < TXN + 100);
  endtask

  task automatic check_events(input string tag, input logic present, input logic [7:0] m,
                              input logic [7:0] l, input int base);
    int exp_ev[8];
    int sack;
    int obs;
    sack = present ? 0 : 1;
    exp_ev[0] = EV_S;
    exp_ev[1] = (8'h90 << 1) | sack;
    exp_ev[2] = (8'h00 << 1) | sack;
    exp_ev[3] = EV_S;
    exp_ev[4] = (8'h91 << 1) | sack;
    exp_ev[5] = (int'(m) << 1);
    exp_ev[6] = (int'(l) << 1) | 1;
    exp_ev[7] = EV_P;
    for (int i = 0; i < 8; i++) begin
      obs = (base + i < ev_q.size()) ? ev_q[base + i] : -1;
      check($sformatf("%s_ev%0d", tag, i), obs, exp_ev[i]);
    end
  endtask

  // Called right after the strobe is seen; consumes one more clock for the width check.
  task automatic check_result(input string tag, input logic present, input logic [7:0] m,
                              input logic [7:0] l, input int base);
    logic [7:0] rm, rl;
    rm = present ? m : 8'hFF;
    rl = present ? l : 8'hFF;
    check({tag, "_temp"}, temp, model_temp(rm, rl));
    check_events(tag, present, rm, rl, base);
    @(posedge clk);
    #1;
    check({tag, "_strobe_width"}, strobe, 1'b0);
    $display("txn %s: present=%0d msb=%02h lsb=%02h temp=%03h", tag, present, m, l, temp);
  endtask

  task automatic single_txn(input string tag, input logic present, input logic [7:0] m,
                            input logic [7:0] l);
    int base, cyc;
    @(negedge clk);
    slave_present = present;
    msb_v = m;
    lsb_v = l;
    base = ev_q.size();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_strobe(cyc);
    check({tag, "_latency"}, cyc, TXN);
    check_result(tag, present, m, l, base);
  endtask

  initial begin
    int base, base2, cyc;
    logic [7:0] m, l;

    // Reset held with enable high: bus must stay idle.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("rst_scl", scl, 1'b1);
    end
    check("rst_temp", temp, 11'h000);
    check("rst_strobe", strobe, 1'b0);
    check("rst_sda", sda, 1'b1);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    mon_rst = 1'b0;
    repeat (5) @(posedge clk);

    single_txn("noslave", 1'b0, 8'h00, 8'h00);
    repeat (20 * Q) @(posedge clk);
    #1;
    check("noslave_quiet_scl", scl, 1'b1);
    single_txn("pos", 1'b1, 8'h19, 8'h60);
    single_txn("neg", 1'b1, 8'hE7, 8'h00);
    for (int k = 0; k < 4; k++) begin
      m = 8'($urandom_range(0, 255));
      l = 8'($urandom_range(0, 255));
      single_txn($sformatf("rand%0d", k), 1'b1, m, l);
    end

    // Back-to-back reads, then drop enable in the middle of the second one.
    @(negedge clk);
    slave_present = 1'b1;
    msb_v = 8'h3C;
    lsb_v = 8'hA0;
    base = ev_q.size();
    en = 1'b1;
    @(posedge clk);
    wait_strobe(cyc);
    check("b2b_first_latency", cyc, TXN);
    msb_v = 8'h19;
    lsb_v = 8'hE0;
    check_result("b2b1", 1'b1, 8'h3C, 8'hA0, base);
    base2 = base + 8;
    repeat (TXN / 2) @(posedge clk);
    en = 1'b0;
    // DONE, one IDLE cycle, then a full transaction; one clock was used by the width check.
    wait_strobe(cyc);
    check("b2b_gap", cyc + TXN / 2, TXN + 1);
    check_result("b2b2", 1'b1, 8'h19, 8'hE0, base2);
    repeat (20 * Q) @(posedge clk);
    #1;
    check("b2b_no_restart", ev_q.size() - base, 16);
    check("b2b_idle_scl", scl, 1'b1);

    // Reset during RD_MSB, then restart straight out of reset.
    @(negedge clk);
    msb_v = 8'h55;
    lsb_v = 8'h20;
    en = 1'b1;
    @(posedge clk);
    repeat (31 * 4 * Q) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mon_rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_scl", scl, 1'b1);
    check("midrst_sda", sda, 1'b1);
    check("midrst_temp", temp, 11'h000);
    check("midrst_strobe", strobe, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_rst = 1'b0;
    base = ev_q.size();
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_strobe(cyc);
    check("after_rst_latency", cyc, TXN);
    check_result("after_rst", 1'b1, 8'h55, 8'h20, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
